// File: rtl/spi_peripheral.sv
// spi_peripheral: SPI mode 0-3 responder oversampled on i_clk; SPI_PERIPHERAL_UNDERRUN_EN adds o_underrun.
// Latency: o_rx_valid follows the last sample edge of a word by the synchronizer depth plus edge detect/register.
// Backpressure: one-entry TX buffer, o_tx_ready low while full; an empty buffer at word start sends zeros.
module spi_peripheral #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [2:0]            i_config,
  input  logic [DATA_WIDTH-1:0] i_tx,
  input  logic                  i_tx_valid,
  output logic                  o_tx_ready,
  output logic [DATA_WIDTH-1:0] o_rx,
  output logic                  o_rx_valid,
  output logic                  o_busy,
  input  logic                  i_sclk,
  input  logic                  i_cs_n,
  input  logic                  i_copi,
  output logic                  o_cipo
`ifdef SPI_PERIPHERAL_UNDERRUN_EN
  ,
  output logic                  o_underrun
`endif
);

  localparam int CW = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {ST_WAIT, ST_IDLE, ST_ACTIVE} state_t;

  state_t                  state;
  logic [SYNC_STAGES-1:0]  sclk_sr, cs_sr, copi_sr;
  logic                    sclk_d, cs_d;
  logic [1:0]              mode;
  logic [CW-1:0]           bit_cnt;
  logic                    byte_done;
  logic [DATA_WIDTH-2:0]   shift_rx;
  logic [DATA_WIDTH-1:0]   shift_tx, tx_buf, rx_next, load_dat;
  logic                    buf_full;
  logic                    sclk_s, cs_s, copi_s;
  logic                    sclk_chg, lead_edge, trail_edge, sample_edge, shift_edge;
  logic                    cs_fall, cs_rise, load, tx_wr;
`ifdef SPI_PERIPHERAL_UNDERRUN_EN
  logic                    underrun_q;
  assign o_underrun = underrun_q;
`endif

  assign sclk_s      = sclk_sr[SYNC_STAGES-1];
  assign cs_s        = cs_sr[SYNC_STAGES-1];
  assign copi_s      = copi_sr[SYNC_STAGES-1];
  assign sclk_chg    = sclk_s ^ sclk_d;
  assign lead_edge   = sclk_chg & (sclk_d == mode[1]);
  assign trail_edge  = sclk_chg & (sclk_s == mode[1]);
  assign sample_edge = mode[0] ? trail_edge : lead_edge;
  assign shift_edge  = mode[0] ? lead_edge : trail_edge;
  assign cs_fall     = cs_d & ~cs_s;
  assign cs_rise     = ~cs_d & cs_s;
  assign rx_next     = {shift_rx, copi_s};
  assign load_dat    = buf_full ? tx_buf : '0;
  assign tx_wr       = i_tx_valid & ~buf_full;
  assign o_tx_ready  = ~buf_full;
  assign o_cipo      = shift_tx[DATA_WIDTH-1];

  // Word start: CPHA=0 loads at CS fall and on the shift edge after a full word,
  // CPHA=1 loads on the leading edge that begins a word.
  always_comb begin
    load = 1'b0;
    if (state == ST_IDLE) begin
      load = cs_fall & ~mode[0];
    end else if (state == ST_ACTIVE && !cs_rise) begin
      load = mode[0] ? (lead_edge && bit_cnt == '0) : (shift_edge && byte_done);
    end
  end

  // Synchronizers reset low so a frame already under way at reset release is never mistaken for idle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sclk_sr <= '0;
      cs_sr   <= '0;
      copi_sr <= '0;
      sclk_d  <= 1'b0;
      cs_d    <= 1'b0;
    end else begin
      sclk_sr <= {sclk_sr[SYNC_STAGES-2:0], i_sclk};
      cs_sr   <= {cs_sr[SYNC_STAGES-2:0], i_cs_n};
      copi_sr <= {copi_sr[SYNC_STAGES-2:0], i_copi};
      sclk_d  <= sclk_s;
      cs_d    <= cs_s;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= ST_WAIT;
      mode       <= 2'b00;
      bit_cnt    <= '0;
      byte_done  <= 1'b0;
      shift_rx   <= '0;
      shift_tx   <= '0;
      tx_buf     <= '0;
      buf_full   <= 1'b0;
      o_rx       <= '0;
      o_rx_valid <= 1'b0;
      o_busy     <= 1'b0;
`ifdef SPI_PERIPHERAL_UNDERRUN_EN
      underrun_q <= 1'b0;
`endif
    end else begin
      o_rx_valid <= 1'b0;
`ifdef SPI_PERIPHERAL_UNDERRUN_EN
      underrun_q <= load & ~buf_full;
`endif
      // A write colliding with a load from an empty buffer survives for the next word.
      if (tx_wr) begin
        tx_buf   <= i_tx;
        buf_full <= 1'b1;
      end else if (load) begin
        buf_full <= 1'b0;
      end

      if (load) begin
        shift_tx <= load_dat;
      end

      if (state != ST_ACTIVE && i_config[0]) begin
        mode <= i_config[2:1];
      end

      case (state)
        ST_WAIT: begin
          if (cs_s) begin
            state <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (cs_fall) begin
            state     <= ST_ACTIVE;
            o_busy    <= 1'b1;
            bit_cnt   <= '0;
            byte_done <= 1'b0;
          end
        end
        ST_ACTIVE: begin
          if (cs_rise) begin
            state     <= ST_IDLE;
            o_busy    <= 1'b0;
            bit_cnt   <= '0;
            byte_done <= 1'b0;
            shift_tx  <= '0;
          end else begin
            if (shift_edge) begin
              byte_done <= 1'b0;
              if (!load) begin
                shift_tx <= {shift_tx[DATA_WIDTH-2:0], 1'b0};
              end
            end
            if (sample_edge) begin
              shift_rx <= rx_next[DATA_WIDTH-2:0];
              if (bit_cnt == CW'(DATA_WIDTH - 1)) begin
                o_rx       <= rx_next;
                o_rx_valid <= 1'b1;
                bit_cnt    <= '0;
                byte_done  <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt + CW'(1);
              end
            end
          end
        end
        default: state <= ST_WAIT;
      endcase
    end
  end

endmodule
